sys_array_tile_sched: RTL and testbench

// - Sequential tile scheduler for the systolic array: splits C[M x N] = A[M x K] * W[K x N]

---
 rtl/sys_array_tile_sched.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sys_array_tile_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_tile_sched.sv
// Tile scheduler: splits C[MxN] = A[MxK] * W[KxN] into array-sized tile descriptors
// with K-split accumulate flags. Define SYS_SPLIT_ZIGZAG_EN for serpentine column-band order.
module sys_array_tile_sched #(
    parameter int unsigned DIM_W   = 16,
    parameter int unsigned ARRAY_W = 4,
    parameter int unsigned ARRAY_L = 4,
    parameter int unsigned ARRAY_K = 4,
    parameter int unsigned IDX_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [DIM_W-1:0] dim_kw,
    input  logic [DIM_W-1:0] dim_n,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic [DIM_W-1:0] tile_row,
    output logic [DIM_W-1:0] tile_col,
    output logic [DIM_W-1:0] tile_kb,
    output logic [DIM_W-1:0] tile_rows,
    output logic [DIM_W-1:0] tile_cols,
    output logic [DIM_W-1:0] tile_k,
    output logic             tile_first_k,
    output logic             tile_last_k,
    output logic             tile_last,
    output logic [IDX_W-1:0] tile_idx,
    output logic             busy,
    output logic             ready,
    output logic             error
);
    localparam int unsigned EW = DIM_W + 1;
    localparam logic [EW-1:0] CH_M = EW'(ARRAY_W);
    localparam logic [EW-1:0] CH_N = EW'(ARRAY_L);
    localparam logic [EW-1:0] CH_K = EW'(ARRAY_K);
    localparam logic [DIM_W-1:0] STEP_M = DIM_W'(ARRAY_W);
    localparam logic [DIM_W-1:0] STEP_N = DIM_W'(ARRAY_L);
    localparam logic [DIM_W-1:0] STEP_K = DIM_W'(ARRAY_K);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EMIT, S_DONE} state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0] m_q, k_q, kw_q, n_q;
    logic [DIM_W-1:0] m_nxt, k_nxt, kw_nxt, n_nxt;
    logic [DIM_W-1:0] row_nxt, col_nxt, kb_nxt, rows_nxt, cols_nxt, k_size_nxt;
    logic             first_k_nxt, last_k_nxt, last_nxt, valid_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             busy_nxt, ready_nxt, error_nxt;

    logic [DIM_W-1:0] nb_row, nb_col, nb_kb;
    logic [EW-1:0]    rem_m, rem_n, rem_k;
    logic [DIM_W-1:0] d_rows, d_cols, d_k;
    logic             d_last_k, d_last_row, d_last_col;
    logic             cur_last_col;
    logic             dims_bad;

`ifdef SYS_SPLIT_ZIGZAG_EN
    logic             odd_q, odd_nxt, nb_odd;
    logic [DIM_W-1:0] last_col_base;
`endif

    assign dims_bad = (m_q == '0) || (k_q == '0) || (n_q == '0) || (kw_q != k_q);

    // Base of the tile loaded next: origin from CHECK, otherwise advance K, then N, then M.
    always_comb begin : base_step
        nb_row = tile_row;
        nb_col = tile_col;
        nb_kb  = tile_kb;
`ifdef SYS_SPLIT_ZIGZAG_EN
        last_col_base = (n_q - DIM_W'(1)) - ((n_q - DIM_W'(1)) % STEP_N);
        cur_last_col  = odd_q ? (tile_col == '0) : ((EW'(tile_col) + CH_N) >= EW'(n_q));
        nb_odd        = odd_q;
`else
        cur_last_col  = (EW'(tile_col) + CH_N) >= EW'(n_q);
`endif
        if (state == S_CHECK) begin
            nb_row = '0;
            nb_col = '0;
            nb_kb  = '0;
`ifdef SYS_SPLIT_ZIGZAG_EN
            nb_odd = 1'b0;
`endif
        end else if (!tile_last_k) begin
            nb_kb = tile_kb + STEP_K;
        end else begin
            nb_kb = '0;
            if (!cur_last_col) begin
`ifdef SYS_SPLIT_ZIGZAG_EN
                nb_col = odd_q ? (tile_col - STEP_N) : (tile_col + STEP_N);
`else
                nb_col = tile_col + STEP_N;
`endif
            end else begin
                nb_row = tile_row + STEP_M;
`ifdef SYS_SPLIT_ZIGZAG_EN
                nb_odd = !odd_q;
                nb_col = nb_odd ? last_col_base : '0;
`else
                nb_col = '0;
`endif
            end
        end
    end

    // Tile sizes and boundary flags for the next base; remainders kept one bit wider.
    always_comb begin : descriptor
        rem_m      = EW'(m_q) - EW'(nb_row);
        rem_n      = EW'(n_q) - EW'(nb_col);
        rem_k      = EW'(k_q) - EW'(nb_kb);
        d_rows     = (rem_m < CH_M) ? DIM_W'(rem_m) : DIM_W'(CH_M);
        d_cols     = (rem_n < CH_N) ? DIM_W'(rem_n) : DIM_W'(CH_N);
        d_k        = (rem_k < CH_K) ? DIM_W'(rem_k) : DIM_W'(CH_K);
        d_last_k   = (EW'(nb_kb) + EW'(d_k)) == EW'(k_q);
        d_last_row = (EW'(nb_row) + CH_M) >= EW'(m_q);
`ifdef SYS_SPLIT_ZIGZAG_EN
        d_last_col = nb_odd ? (nb_col == '0) : ((EW'(nb_col) + CH_N) >= EW'(n_q));
`else
        d_last_col = (EW'(nb_col) + CH_N) >= EW'(n_q);
`endif
    end

    always_comb begin : next_state
        logic load;
        state_nxt   = state;
        m_nxt       = m_q;
        k_nxt       = k_q;
        kw_nxt      = kw_q;
        n_nxt       = n_q;
        row_nxt     = tile_row;
        col_nxt     = tile_col;
        kb_nxt      = tile_kb;
        rows_nxt    = tile_rows;
        cols_nxt    = tile_cols;
        k_size_nxt  = tile_k;
        first_k_nxt = tile_first_k;
        last_k_nxt  = tile_last_k;
        last_nxt    = tile_last;
        valid_nxt   = tile_valid;
        idx_nxt     = tile_idx;
        busy_nxt    = busy;
        ready_nxt   = 1'b0;
        error_nxt   = error;
        load        = 1'b0;
`ifdef SYS_SPLIT_ZIGZAG_EN
        odd_nxt     = odd_q;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    m_nxt     = dim_m;
                    k_nxt     = dim_k;
                    kw_nxt    = dim_kw;
                    n_nxt     = dim_n;
                    error_nxt = 1'b0;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort || dims_bad) begin
                    error_nxt = abort ? error : 1'b1;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    load      = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (abort) begin
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else if (tile_valid && tile_ready) begin
                    idx_nxt = tile_idx + IDX_W'(1);
                    if (tile_last) begin
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        ready_nxt = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (load) begin
            row_nxt     = nb_row;
            col_nxt     = nb_col;
            kb_nxt      = nb_kb;
            rows_nxt    = d_rows;
            cols_nxt    = d_cols;
            k_size_nxt  = d_k;
            first_k_nxt = (nb_kb == '0);
            last_k_nxt  = d_last_k;
            last_nxt    = d_last_k && d_last_col && d_last_row;
`ifdef SYS_SPLIT_ZIGZAG_EN
            odd_nxt     = nb_odd;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin : regs
        if (reset) begin
            state        <= S_IDLE;
            m_q          <= '0;
            k_q          <= '0;
            kw_q         <= '0;
            n_q          <= '0;
            tile_row     <= '0;
            tile_col     <= '0;
            tile_kb      <= '0;
            tile_rows    <= '0;
            tile_cols    <= '0;
            tile_k       <= '0;
            tile_first_k <= 1'b0;
            tile_last_k  <= 1'b0;
            tile_last    <= 1'b0;
            tile_valid   <= 1'b0;
            tile_idx     <= '0;
            busy         <= 1'b0;
            ready        <= 1'b0;
            error        <= 1'b0;
`ifdef SYS_SPLIT_ZIGZAG_EN
            odd_q        <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            m_q          <= m_nxt;
            k_q          <= k_nxt;
            kw_q         <= kw_nxt;
            n_q          <= n_nxt;
            tile_row     <= row_nxt;
            tile_col     <= col_nxt;
            tile_kb      <= kb_nxt;
            tile_rows    <= rows_nxt;
            tile_cols    <= cols_nxt;
            tile_k       <= k_size_nxt;
            tile_first_k <= first_k_nxt;
            tile_last_k  <= last_k_nxt;
            tile_last    <= last_nxt;
            tile_valid   <= valid_nxt;
            tile_idx     <= idx_nxt;
            busy         <= busy_nxt;
            ready        <= ready_nxt;
            error        <= error_nxt;
`ifdef SYS_SPLIT_ZIGZAG_EN
            odd_q        <= odd_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sys_array_tile_sched.sv
// Directed bench for sys_array_tile_sched: loop-nest reference model feeds a descriptor queue.
// Honors SYS_SPLIT_ZIGZAG_EN for the expected column-band order.
module tb_sys_array_tile_sched;
    localparam int AW = 4;
    localparam int AL = 4;
    localparam int AK = 4;

    typedef struct packed {
        logic [15:0] row, col, kb, rows, cols, k;
        logic        first_k, last_k, last;
        logic [15:0] idx;
    } desc_t;

    logic        clk, reset, start, abort, tile_ready;
    logic [15:0] dim_m, dim_k, dim_kw, dim_n;
    logic        tile_valid, tile_first_k, tile_last_k, tile_last, busy, ready, error;
    logic [15:0] tile_row, tile_col, tile_kb, tile_rows, tile_cols, tile_k, tile_idx;

    desc_t q[$];
    int    tests = 0;
    int    fails = 0;

    sys_array_tile_sched dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .dim_m(dim_m), .dim_k(dim_k), .dim_kw(dim_kw), .dim_n(dim_n),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_row(tile_row), .tile_col(tile_col), .tile_kb(tile_kb),
        .tile_rows(tile_rows), .tile_cols(tile_cols), .tile_k(tile_k),
        .tile_first_k(tile_first_k), .tile_last_k(tile_last_k), .tile_last(tile_last),
        .tile_idx(tile_idx), .busy(busy), .ready(ready), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic desc_t observed();
        return {tile_row, tile_col, tile_kb, tile_rows, tile_cols, tile_k,
                tile_first_k, tile_last_k, tile_last, tile_idx};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference order: row band, then column band, then K chunk.
    task automatic push_expected(input int m, input int k, input int n);
        int    idx;
        int    band;
        int    nbands;
        int    cb;
        desc_t d;
        idx    = 0;
        band   = 0;
        nbands = (n + AL - 1) / AL;
        for (int r = 0; r < m; r += AW) begin
            for (int ci = 0; ci < nbands; ci++) begin
                cb = ci;
`ifdef SYS_SPLIT_ZIGZAG_EN
                if (band % 2 == 1) cb = nbands - 1 - ci;
`endif
                for (int kb = 0; kb < k; kb += AK) begin
                    d.row     = 16'(r);
                    d.col     = 16'(cb * AL);
                    d.kb      = 16'(kb);
                    d.rows    = 16'((m - r < AW) ? m - r : AW);
                    d.cols    = 16'((n - cb * AL < AL) ? n - cb * AL : AL);
                    d.k       = 16'((k - kb < AK) ? k - kb : AK);
                    d.first_k = (kb == 0);
                    d.last_k  = (kb + AK >= k);
                    d.last    = d.last_k && (ci == nbands - 1) && (r + AW >= m);
                    d.idx     = 16'(idx);
                    idx++;
                    q.push_back(d);
                end
            end
            band = band + 1;
        end
    endtask

    task automatic run_job(input int m, input int k, input int kw, input int n,
                           input int stall_at, input int stall_len,
                           input bit abort_mid, input bit abort_at_start);
        int    cyc;
        int    scnt;
        bit    fin;
        bit    aborted;
        bit    bad;
        desc_t e;
        bad = (m == 0) || (k == 0) || (n == 0) || (kw != k);
        q.delete();
        if (!bad) push_expected(m, k, n);
        dim_m  = 16'(m);
        dim_k  = 16'(k);
        dim_kw = 16'(kw);
        dim_n  = 16'(n);
        start  = 1'b1;
        abort  = abort_at_start;
        tile_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("busy_after_start", busy, 1);
        check("error_cleared", error, 0);
        check("no_valid_in_check", tile_valid, 0);
        @(posedge clk); #1;
        if (bad) begin
            check("error_set", error, 1);
            check("error_ready", ready, 1);
            check("error_no_valid", tile_valid, 0);
            check("error_busy", busy, 0);
            @(posedge clk); #1;
            check("error_ready_pulse", ready, 0);
            check("error_held", error, 1);
            return;
        end
        cyc = 0; scnt = 0; fin = 0; aborted = 0;
        while (!fin && cyc < 300) begin
            check("tile_valid", tile_valid, 1);
            if (q.size() == 0) begin
                check("extra_tile", tile_valid, 0);
                fin = 1;
            end else begin
                e = q[0];
                check("desc", 128'(observed()), 128'(e));
                if (32'(e.idx) == stall_at && scnt < stall_len) begin
                    tile_ready = 1'b0;
                    scnt++;
                    start = (scnt == 2);
                    if (abort_mid && scnt == 3) begin
                        abort   = 1'b1;
                        fin     = 1;
                        aborted = 1;
                    end
                end else begin
                    tile_ready = 1'b1;
                    start = 1'b0;
                    void'(q.pop_front());
                    if (e.last) fin = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        abort = 1'b0;
        tile_ready = 1'b0;
        if (!fin) check("timeout", fin, 1);
        check("done_ready", ready, 1);
        check("done_busy", busy, 0);
        check("done_valid", tile_valid, 0);
        if (!aborted) check("all_tiles_seen", q.size(), 0);
        @(posedge clk); #1;
        check("ready_one_cycle", ready, 0);
        check("idle_valid", tile_valid, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; tile_ready = 1'b0;
        dim_m = '0; dim_k = '0; dim_kw = '0; dim_n = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_desc", 128'(observed()), '0);
        check("reset_valid", tile_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", ready, 0);
        check("reset_error", error, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        run_job(5, 2, 2, 5, -1, 0, 0, 0);
        run_job(4, 10, 10, 4, -1, 0, 0, 0);
        run_job(5, 2, 2, 5, 1, 5, 0, 0);
        run_job(5, 2, 3, 5, -1, 0, 0, 0);
        run_job(5, 2, 2, 0, -1, 0, 0, 0);
        run_job(9, 5, 5, 7, -1, 0, 0, 1);
        run_job(5, 2, 2, 5, 2, 10, 1, 0);
        check("abort_error_unchanged", error, 0);
        run_job(5, 2, 2, 5, -1, 0, 0, 0);

        // Asynchronous reset while a tile is being offered.
        dim_m = 16'd5; dim_k = 16'd2; dim_kw = 16'd2; dim_n = 16'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", tile_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_desc", 128'(observed()), '0);
        check("async_reset_valid", tile_valid, 0);
        check("async_reset_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("async_reset_no_ready", ready, 0);
        run_job(3, 3, 3, 3, -1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
